// File: rtl/port_in_debounce.sv
// port_in_debounce: 2-FF synchronised, tick-debounced input port with sticky rise events.
// Define PORT_IN_REPEAT_EN to auto-repeat events for keys held high.
module port_in_debounce #(
  parameter int WIDTH     = 8,
  parameter int TICK_DIV  = 1000,
  parameter int DB_TICKS  = 10,
  parameter int RPT_DELAY = 50,
  parameter int RPT_RATE  = 10
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] evt,
  output logic             any_event,
  input  logic [WIDTH-1:0] clr,
  input  logic             clr_we
);
  localparam int PW = $clog2(TICK_DIV);
  logic [WIDTH-1:0] s1, s, state_next, evt_next, rpt_set;
  logic [PW-1:0]    presc;
  logic             tick;
  logic [3:0]       c      [WIDTH];
  logic [3:0]       c_next [WIDTH];

  if (TICK_DIV < 2 || DB_TICKS < 1 || DB_TICKS > 15 || RPT_RATE < 1 ||
      RPT_RATE > RPT_DELAY || RPT_DELAY > 255) begin : g_param_check
    $error("port_in_debounce: parameter out of range");
  end

  assign tick = presc == PW'(TICK_DIV - 1);

  always_comb begin
    state_next = state;
    for (int i = 0; i < WIDTH; i++) begin
      c_next[i] = (s[i] == state[i]) ? 4'd0 :
                  !tick ? c[i] :
                  (c[i] == 4'(DB_TICKS - 1)) ? 4'd0 : c[i] + 4'd1;
      if (tick && s[i] != state[i] && c[i] == 4'(DB_TICKS - 1)) state_next[i] = s[i];
    end
    evt_next = (evt & ~(clr_we ? clr : '0)) | (state_next & ~state) | rpt_set;
  end

`ifdef PORT_IN_REPEAT_EN
  logic [7:0] r, r_inc;
  logic       fire;
  assign r_inc   = (r == 8'hFF) ? r : r + 8'd1;
  // a changing state restarts the repeat window, so it never fires in that cycle
  assign fire    = tick && (|state) && state_next == state && r_inc == 8'(RPT_DELAY);
  assign rpt_set = fire ? state : '0;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r <= '0;
    else if (state_next != state || state == '0) r <= '0;
    else if (tick) r <= fire ? 8'(RPT_DELAY - RPT_RATE) : r_inc;
  end
`else
  assign rpt_set = '0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1        <= '0;
      s         <= '0;
      presc     <= '0;
      state     <= '0;
      evt       <= '0;
      any_event <= 1'b0;
      for (int i = 0; i < WIDTH; i++) c[i] <= '0;
    end else begin
      s1        <= pin;
      s         <= s1;
      presc     <= tick ? '0 : presc + PW'(1);
      state     <= state_next;
      evt       <= evt_next;
      any_event <= |evt;
      for (int i = 0; i < WIDTH; i++) c[i] <= c_next[i];
    end
  end
endmodule

// File: tb/tb_port_in_debounce.sv
// tb_port_in_debounce: directed scoreboard bench for port_in_debounce (TICK_DIV=4, DB_TICKS=3).
// Covers PORT_IN_REPEAT_EN when the same macro is defined for the bench build.
module tb_port_in_debounce;
  logic       clock = 1'b0, reset_n = 1'b0, clr_we = 1'b0, any_event;
  logic [7:0] pin = 8'h00, clr = 8'h00, state, evt;
  int         checks = 0, failures = 0, n;

  typedef struct {
    string      tag;
    logic [7:0] st;
    logic [7:0] ev;
    logic       any;
  } exp_t;
  exp_t q[$];

  always #5 clock = ~clock;

  port_in_debounce #(.WIDTH(8), .TICK_DIV(4), .DB_TICKS(3), .RPT_DELAY(6), .RPT_RATE(2)) dut (
    .clock(clock), .reset_n(reset_n), .pin(pin), .state(state), .evt(evt),
    .any_event(any_event), .clr(clr), .clr_we(clr_we));

  task automatic push(input string tag, input logic [7:0] st, input logic [7:0] ev, input logic any);
    q.push_back('{tag, st, ev, any});
  endtask

  task automatic check_pop();
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty got=%0d required=1", q.size());
    end else begin
      e = q.pop_front();
      assert (state === e.st && evt === e.ev && any_event === e.any) else begin
        failures++;
        $error("FAIL %s state=%h evt=%h any=%b required state=%h evt=%h any=%b",
               e.tag, state, evt, any_event, e.st, e.ev, e.any);
      end
    end
  endtask

  task automatic check_range(input string tag, input int v, input int lo, input int hi);
    checks++;
    assert (v >= lo && v <= hi) else begin
      failures++;
      $error("FAIL %s got=%0d required=%0d..%0d", tag, v, lo, hi);
    end
  endtask

  task automatic wait_change(input int budget, output int cyc);
    logic [7:0] start;
    start = state;
    cyc = 0;
    while (state === start && cyc < budget) begin
      @(negedge clock);
      cyc++;
    end
    if (state === start) begin
      checks++;
      failures++;
      $error("FAIL wait_change state=%h stayed, required a change within %0d cycles", state, budget);
    end
  endtask

  task automatic clear_pulse(input logic [7:0] mask);
    clr = mask;
    clr_we = 1'b1;
    @(negedge clock);
    clr_we = 1'b0;
  endtask

`ifdef PORT_IN_REPEAT_EN
  task automatic wait_evt1(input int budget, output int cyc);
    cyc = 0;
    while (evt[1] !== 1'b1 && cyc < budget) begin
      @(negedge clock);
      cyc++;
    end
  endtask
`endif

  initial begin
    pin = 8'hFF;
    repeat (3) @(negedge clock);
    push("reset", 8'h00, 8'h00, 1'b0);
    check_pop();
    reset_n = 1'b1;
    push("release_state", 8'hFF, 8'hFF, 1'b0);
    wait_change(20, n);
    check_pop();
    check_range("release_latency", n, 11, 14);
    push("release_any", 8'hFF, 8'hFF, 1'b1);
    @(negedge clock);
    check_pop();
    push("clear_all", 8'hFF, 8'h00, 1'b1);
    clear_pulse(8'hFF);
    check_pop();
    push("any_drop", 8'hFF, 8'h00, 1'b0);
    @(negedge clock);
    check_pop();
    pin = 8'h00;
    push("fall_all", 8'h00, 8'h00, 1'b0);
    wait_change(20, n);
    check_pop();

    pin = 8'h01;
    push("glitch", 8'h00, 8'h00, 1'b0);
    repeat (3) @(negedge clock);
    pin = 8'h00;
    repeat (20) @(negedge clock);
    check_pop();

    pin = 8'h04;
    push("rise2", 8'h04, 8'h04, 1'b0);
    wait_change(20, n);
    check_pop();
    check_range("rise2_latency", n, 11, 14);
    push("clear2", 8'h04, 8'h00, 1'b1);
    clear_pulse(8'h04);
    check_pop();

    pin = 8'h00;
    push("fall2", 8'h00, 8'h00, 1'b0);
    wait_change(20, n);
    check_pop();

    // clear held on bit 3 through the rising edge: the set must still land
    pin = 8'h08;
    clr = 8'h08;
    clr_we = 1'b1;
    push("set_wins", 8'h08, 8'h08, 1'b0);
    wait_change(20, n);
    clr_we = 1'b0;
    check_pop();
    push("set_wins_any", 8'h08, 8'h08, 1'b1);
    @(negedge clock);
    check_pop();
    pin = 8'h00;
    clear_pulse(8'h08);
    push("fall3", 8'h00, 8'h00, 1'b0);
    wait_change(20, n);
    check_pop();

    pin = 8'h60;
    push("dual_rise", 8'h60, 8'h60, 1'b0);
    wait_change(20, n);
    check_pop();
    pin = 8'h00;
    clear_pulse(8'h60);
    push("dual_fall", 8'h00, 8'h00, 1'b0);
    wait_change(20, n);
    check_pop();

    pin = 8'h02;
    push("hold", 8'h02, 8'h02, 1'b0);
    wait_change(20, n);
    check_pop();
    clear_pulse(8'h02);
`ifdef PORT_IN_REPEAT_EN
    push("repeat_first", 8'h02, 8'h02, 1'b0);
    wait_evt1(40, n);
    check_pop();
    check_range("repeat_first_gap", n + 1, 24, 24);
    for (int k = 0; k < 2; k++) begin
      clear_pulse(8'h02);
      push("repeat_next", 8'h02, 8'h02, 1'b0);
      wait_evt1(20, n);
      check_pop();
      check_range("repeat_next_gap", n + 1, 8, 8);
    end
`else
    push("no_repeat", 8'h02, 8'h00, 1'b0);
    repeat (40) @(negedge clock);
    check_pop();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
